// File: rtl/spell_mem_master.sv
// Initiator for the spell memory port: runs one core load/store at a time over the
// select/data_ready handshake, with a responder timeout and an enforced idle gap.
module spell_mem_master #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_data_space,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  output logic       mem_select,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_memory_type_data,
  output logic       mem_write,
  input  logic [7:0] mem_rdata,
  input  logic       mem_data_ready
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RELEASE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Only combinational output: lets the core see acceptance in the same cycle.
  assign req_ready = (state == IDLE) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state                <= IDLE;
      cnt                  <= '0;
      mem_select           <= 1'b0;
      mem_write            <= 1'b0;
      mem_memory_type_data <= 1'b0;
      mem_addr             <= '0;
      mem_wdata            <= '0;
      rsp_valid            <= 1'b0;
      rsp_error            <= 1'b0;
      rsp_rdata            <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            mem_write            <= req_write;
            mem_memory_type_data <= req_data_space;
            mem_addr             <= req_addr;
            mem_wdata            <= req_wdata;
            mem_select           <= 1'b1;
            cnt                  <= '0;
            state                <= ACCESS;
          end
        end
        ACCESS: begin
          // data_ready is checked first so it wins a tie with the timeout.
          if (mem_data_ready) begin
            mem_select <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_error  <= 1'b0;
            rsp_rdata  <= mem_write ? 8'd0 : mem_rdata;
            state      <= RELEASE;
          end else if (cnt == CNT_LAST) begin
            mem_select <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_error  <= 1'b1;
            rsp_rdata  <= 8'd0;
            state      <= RELEASE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          // Wait for the responder to drop data_ready before taking new work.
          if (!mem_data_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spell_mem_master.sv
// Bench for spell_mem_master: behavioural responder with programmable latency,
// data_ready hold and stuck modes, checked against a reference memory model.
module tb_spell_mem_master;

  localparam int unsigned TO = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic       req_data_space = 1'b0;
  logic [7:0] req_addr = 8'd0;
  logic [7:0] req_wdata = 8'd0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic       mem_select;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_memory_type_data;
  logic       mem_write;
  logic [7:0] mem_rdata;
  logic       mem_data_ready;

  spell_mem_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_data_space(req_data_space),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .mem_select(mem_select),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_memory_type_data(mem_memory_type_data),
    .mem_write(mem_write),
    .mem_rdata(mem_rdata),
    .mem_data_ready(mem_data_ready)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  logic [7:0] dev_code[256];
  logic [7:0] dev_data[256];
  logic [7:0] ref_code[256];
  logic [7:0] ref_data[256];

  int   r_lat = 0;
  int   r_hold = 0;
  logic r_stuck = 1'b0;
  int   wait_cnt = 0;
  int   hold_cnt = 0;
  logic ready_phase = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Responder: acts just after each rising edge, like a registered memory would.
  initial begin
    mem_data_ready = 1'b0;
    mem_rdata = 8'd0;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        ready_phase = 1'b0;
        wait_cnt = 0;
        mem_data_ready = 1'b0;
      end else if (ready_phase) begin
        if (!mem_select) begin
          if (hold_cnt >= r_hold) begin
            mem_data_ready = 1'b0;
            ready_phase = 1'b0;
            wait_cnt = 0;
          end else begin
            hold_cnt++;
          end
        end
      end else if (mem_select && !r_stuck) begin
        if (wait_cnt >= r_lat) begin
          mem_data_ready = 1'b1;
          ready_phase = 1'b1;
          hold_cnt = 0;
          if (mem_write) begin
            if (mem_memory_type_data) dev_data[mem_addr] = mem_wdata;
            else dev_code[mem_addr] = mem_wdata;
            mem_rdata = 8'($urandom);
          end else begin
            mem_rdata = mem_memory_type_data ? dev_data[mem_addr] : dev_code[mem_addr];
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        mem_data_ready = 1'b0;
        wait_cnt = 0;
        mem_rdata = 8'($urandom);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  // One transaction, predicted from the request and the responder's behaviour mode.
  task automatic run_txn(input logic wr, input logic sp, input logic [7:0] a,
                         input logic [7:0] d, input int lat, input int hold,
                         input logic stuck);
    logic [7:0] exp_rd;
    int exp_sel, exp_k, sel_cnt, cyc, k;
    logic seen, ready_bad, fld_bad, sel_bad;
    r_lat = lat;
    r_hold = hold;
    r_stuck = stuck;
    exp_rd = 8'd0;
    if (!stuck) begin
      if (wr) begin
        if (sp) ref_data[a] = d;
        else ref_code[a] = d;
      end else begin
        exp_rd = sp ? ref_data[a] : ref_code[a];
      end
    end
    exp_sel = stuck ? int'(TO) : lat + 1;
    exp_k = stuck ? 1 : hold + 1;

    wait_ready();
    req_valid = 1'b1;
    req_write = wr;
    req_data_space = sp;
    req_addr = a;
    req_wdata = d;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_data_space = 1'($urandom);
    req_addr = 8'($urandom);
    req_wdata = 8'($urandom);

    sel_cnt = 0; cyc = 0; seen = 1'b0; ready_bad = 1'b0; fld_bad = 1'b0;
    while (!seen && cyc < int'(TO) + 10) begin
      @(negedge clock);
      cyc++;
      if (rsp_valid) begin
        seen = 1'b1;
      end else begin
        if (mem_select) sel_cnt++;
        if (req_ready) ready_bad = 1'b1;
        if (mem_select && (mem_addr != a || mem_wdata != d || mem_write != wr ||
                           mem_memory_type_data != sp)) fld_bad = 1'b1;
      end
    end
    check("rsp_seen", 32'(seen), 32'd1);
    check("rsp_error", 32'(rsp_error), 32'(stuck));
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    check("sel_low_at_rsp", 32'(mem_select), 32'd0);
    check("sel_cycles", 32'(sel_cnt), 32'(exp_sel));
    check("ready_low_access", 32'(ready_bad), 32'd0);
    check("mem_fields", 32'(fld_bad), 32'd0);

    k = 0; sel_bad = 1'b0;
    do begin
      @(negedge clock);
      k++;
      if (k == 1) check("rsp_pulse", 32'(rsp_valid), 32'd0);
      if (mem_select) sel_bad = 1'b1;
    end while (!req_ready && k < 20);
    check("release_cycles", 32'(k), 32'(exp_k));
    check("sel_gap", 32'(sel_bad), 32'd0);
  endtask

  initial begin
    logic quiet;
    for (int i = 0; i < 256; i++) begin
      dev_code[i] = 8'd0; dev_data[i] = 8'd0;
      ref_code[i] = 8'd0; ref_data[i] = 8'd0;
    end

    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_select", 32'(mem_select), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_ready", 32'(req_ready), 32'd1);

    run_txn(1'b1, 1'b1, 8'd5, 8'd42, 0, 0, 1'b0);
    run_txn(1'b0, 1'b0, 8'd5, 8'd0, 1, 0, 1'b0);
    run_txn(1'b0, 1'b1, 8'd5, 8'd0, 0, 0, 1'b0);
    run_txn(1'b0, 1'b1, 8'd6, 8'd0, 2, 0, 1'b0);
    run_txn(1'b1, 1'b0, 8'd5, 8'd99, 0, 0, 1'b0);
    run_txn(1'b0, 1'b0, 8'd5, 8'd0, 0, 0, 1'b0);
    run_txn(1'b0, 1'b1, 8'd5, 8'd0, 0, 0, 1'b0);
    run_txn(1'b0, 1'b1, 8'd5, 8'd0, 0, 0, 1'b1);
    run_txn(1'b0, 1'b1, 8'd5, 8'd0, 0, 3, 1'b0);
    run_txn(1'b0, 1'b0, 8'd5, 8'd0, int'(TO) - 1, 0, 1'b0);

    // Reset in the middle of a stuck access: no response may appear.
    r_stuck = 1'b1; r_lat = 0; r_hold = 0;
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_data_space = 1'b1;
    req_addr = 8'd5; req_wdata = 8'd77;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_select", 32'(mem_select), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("mrst_select", 32'(mem_select), 32'd0);
    check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mrst_rsp_error", 32'(rsp_error), 32'd0);
    check("mrst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("mrst_addr", 32'(mem_addr), 32'd0);
    check("mrst_wdata", 32'(mem_wdata), 32'd0);
    check("mrst_write", 32'(mem_write), 32'd0);
    check("mrst_type", 32'(mem_memory_type_data), 32'd0);
    check("mrst_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    quiet = 1'b0;
    repeat (TO + 4) begin
      @(negedge clock);
      if (rsp_valid || mem_select) quiet = 1'b1;
    end
    check("mrst_quiet", 32'(quiet), 32'd0);
    run_txn(1'b0, 1'b1, 8'd5, 8'd0, 1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), 1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
              ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
